prt_dprx_trn_seq: RTL and testbench
===================================

PRT_DPRX_TRN_SEQ -- requirements
Module: prt_dprx_trn_seq

Interface
REQ-001 SHALL have parameter P_LANES, default 2, number of physical lanes (1, 2 or 4).
REQ-002 SHALL have parameter P_RETRY, default 3, number of extra measurement attempts after a failing one (0..15).
REQ-003 SHALL have parameter P_SETTLE, default 8, idle cycles between config write and measurement start (1..255).
REQ-004 SHALL have the following ports, one clock; reset is asynchronous and active-high:
- RST_IN  in  1  asynchronous active-high reset
- CLK_IN  in  1  link clock
- START_IN  in  1  single-cycle request to run a training check
- ABORT_IN  in  1  single-cycle abort
- ACT_LANES_IN  in  3  requested active lanes (1, 2 or 4)
- TPS_IN  in  3  training pattern select, applied to every active lane
- WIN_IN  in  16  measurement window in lane cycles
- THR_IN  in  16  minimum match count for a lane to pass
- CFG_LANES_OUT  out  3  active-lane value to training block
- CFG_LANES_VLD_OUT  out  1  CFG_LANES_OUT write strobe
- CFG_TPS_OUT  out  16  per-lane TPS, lane i at bits [4i+2:4i], other bits 0
- CFG_TPS_VLD_OUT  out  1  CFG_TPS_OUT write strobe, restarts lane counters
- STA_CYCLE_IN  in  16  lane-0 cycle counter since last TPS write
- STA_MATCH_IN  in  16*P_LANES  per-lane match counters, lane i at [16i+15:16i]
- BUSY_OUT  out  1  sequence in progress
- DONE_OUT  out  1  single-cycle completion pulse
- PASS_OUT  out  4  per-lane pass flags, valid from DONE_OUT until next START
- ERR_OUT  out  1  invalid request or timeout, valid with PASS_OUT
- TRY_OUT  out  4  attempts used in last sequence

Function
REQ-005 SHALL implement FSM states IDLE, LANES, TPS, SETTLE, MEAS, EVAL, DONE.
REQ-006 In IDLE, START_IN SHALL capture ACT_LANES_IN, TPS_IN, WIN_IN, THR_IN and move to LANES next cycle; BUSY_OUT high from the cycle after START_IN.
REQ-007 START_IN while BUSY_OUT is high SHALL be ignored.
REQ-008 If the captured lane count is not 1, 2 or 4, or exceeds P_LANES, the FSM SHALL go directly to DONE with ERR_OUT=1, PASS_OUT=0, TRY_OUT=0, and emit no config strobes.
REQ-009 LANES SHALL last one cycle asserting CFG_LANES_VLD_OUT with CFG_LANES_OUT = captured lanes, then go to TPS.
REQ-010 TPS SHALL last one cycle asserting CFG_TPS_VLD_OUT, TPS field set for active lanes and zero for inactive lanes, increment the attempt counter, then go to SETTLE.
REQ-011 SETTLE SHALL wait exactly P_SETTLE cycles, then go to MEAS.
REQ-012 MEAS SHALL go to EVAL on the first cycle STA_CYCLE_IN >= max(WIN_IN captured, 1).
REQ-013 MEAS SHALL count its own cycles (16-bit); at 65535 without window completion it SHALL go to DONE with ERR_OUT=1, PASS_OUT=0.
REQ-014 EVAL (one cycle) SHALL set PASS bit i = 1 iff lane i active and STA_MATCH lane i >= captured THR; inactive lanes and lanes >= P_LANES SHALL read 0.
REQ-015 From EVAL: all active lanes pass -> DONE; else if attempts <= P_RETRY -> TPS; else DONE with the last PASS value, ERR_OUT=0.
REQ-016 DONE SHALL last one cycle asserting DONE_OUT, then return to IDLE with BUSY_OUT low.
REQ-017 ABORT_IN in any non-IDLE state SHALL return to IDLE next cycle, with no DONE_OUT, PASS_OUT=0, ERR_OUT=1; ABORT_IN in IDLE ignored; ABORT_IN with START_IN in IDLE: ABORT wins.
REQ-018 CFG strobes SHALL never be asserted in the same cycle, and never outside LANES/TPS.
REQ-019 Comparisons SHALL be unsigned 16-bit; TRY_OUT saturates at 15.

Reset
REQ-020 Reset SHALL force IDLE and all outputs low/zero (CFG_TPS_OUT=0, CFG_LANES_OUT=0, PASS_OUT=0, TRY_OUT=0); reset mid-sequence SHALL abandon it without DONE_OUT.

Verification
REQ-021 P_LANES=2, START with lanes=2, TPS=1, WIN=100, THR=90, matches 100/95 -> one LANES strobe, one TPS strobe (0x0011), DONE_OUT pulse, PASS_OUT=0x3, TRY_OUT=1, ERR_OUT=0.
REQ-022 Lane 1 match 50 on every attempt, P_RETRY=3 -> four TPS strobes, DONE with PASS_OUT=0x1, TRY_OUT=4, ERR_OUT=0.
REQ-023 lanes=4 with P_LANES=2 -> DONE_OUT two cycles after START, ERR_OUT=1, no config strobes.
REQ-024 STA_CYCLE_IN held at 0 -> DONE after 65535 MEAS cycles with ERR_OUT=1, PASS_OUT=0.
REQ-025 ABORT_IN during MEAS -> IDLE next cycle, no DONE_OUT, ERR_OUT=1; a second START during BUSY produces no extra strobes.
REQ-026 Assert RST_IN during SETTLE -> all outputs zero asynchronously; a subsequent START runs a full sequence normally.

Source files
------------

// File: rtl/prt_dprx_trn_seq.sv
// DisplayPort RX link-training check sequencer: writes lane/TPS config to the
// training block, waits for a measurement window, and grades per-lane matches.
// Outputs are registered from the current state, so strobes and DONE_OUT
// appear the cycle after the state that requests them.
module prt_dprx_trn_seq #(
  parameter int unsigned P_LANES  = 2,
  parameter int unsigned P_RETRY  = 3,
  parameter int unsigned P_SETTLE = 8
) (
  input  logic                   RST_IN,
  input  logic                   CLK_IN,
  input  logic                   START_IN,
  input  logic                   ABORT_IN,
  input  logic [2:0]             ACT_LANES_IN,
  input  logic [2:0]             TPS_IN,
  input  logic [15:0]            WIN_IN,
  input  logic [15:0]            THR_IN,
  output logic [2:0]             CFG_LANES_OUT,
  output logic                   CFG_LANES_VLD_OUT,
  output logic [15:0]            CFG_TPS_OUT,
  output logic                   CFG_TPS_VLD_OUT,
  input  logic [15:0]            STA_CYCLE_IN,
  input  logic [16*P_LANES-1:0]  STA_MATCH_IN,
  output logic                   BUSY_OUT,
  output logic                   DONE_OUT,
  output logic [3:0]             PASS_OUT,
  output logic                   ERR_OUT,
  output logic [3:0]             TRY_OUT
);

  localparam int unsigned MATCH_W = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_LANES, S_TPS, S_SETTLE, S_MEAS, S_EVAL, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  lanes_q, lanes_d;
  logic [2:0]  tps_q, tps_d;
  logic [15:0] win_q, win_d;
  logic [15:0] thr_q, thr_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] meas_q, meas_d;
  logic [4:0]  att_q, att_d;
  logic [2:0]  cfg_lanes_q, cfg_lanes_d;
  logic        cfg_lanes_vld_q, cfg_lanes_vld_d;
  logic [15:0] cfg_tps_q, cfg_tps_d;
  logic        cfg_tps_vld_q, cfg_tps_vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  pass_q, pass_d;
  logic        err_q, err_d;
  logic [3:0]  try_q, try_d;

  logic [3:0]         act_c;
  logic [3:0]         pass_c;
  logic [15:0]        tps_field_c;
  logic [15:0]        win_eff_c;
  logic               start_ok_c;
  logic [MATCH_W-1:0] match_pad;

  // Lane mask, per-lane TPS word and per-lane grading from the captured request
  always_comb begin
    match_pad   = MATCH_W'(STA_MATCH_IN);
    win_eff_c   = (win_q == 16'd0) ? 16'd1 : win_q;
    start_ok_c  = ((ACT_LANES_IN == 3'd1) || (ACT_LANES_IN == 3'd2) ||
                   (ACT_LANES_IN == 3'd4)) && (32'(ACT_LANES_IN) <= P_LANES);
    case (lanes_q)
      3'd1:    act_c = 4'b0001;
      3'd2:    act_c = 4'b0011;
      3'd4:    act_c = 4'b1111;
      default: act_c = 4'b0000;
    endcase
    pass_c      = '0;
    tps_field_c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (act_c[i]) tps_field_c[4*i +: 4] = {1'b0, tps_q};
      if (act_c[i] && (i < P_LANES) && (match_pad[16*i +: 16] >= thr_q)) pass_c[i] = 1'b1;
    end
  end

  // Next-state and next-output logic; abort overrides everything outside IDLE
  always_comb begin
    state_d         = state_q;
    lanes_d         = lanes_q;
    tps_d           = tps_q;
    win_d           = win_q;
    thr_d           = thr_q;
    settle_d        = settle_q;
    meas_d          = meas_q;
    att_d           = att_q;
    cfg_lanes_d     = cfg_lanes_q;
    cfg_lanes_vld_d = 1'b0;
    cfg_tps_d       = cfg_tps_q;
    cfg_tps_vld_d   = 1'b0;
    done_d          = 1'b0;
    pass_d          = pass_q;
    err_d           = err_q;
    try_d           = try_q;
    case (state_q)
      S_IDLE: begin
        if (START_IN && !ABORT_IN) begin
          lanes_d = ACT_LANES_IN;
          tps_d   = TPS_IN;
          win_d   = WIN_IN;
          thr_d   = THR_IN;
          att_d   = '0;
          pass_d  = '0;
          try_d   = '0;
          err_d   = !start_ok_c;
          state_d = start_ok_c ? S_LANES : S_DONE;
        end
      end
      S_LANES: begin
        cfg_lanes_vld_d = 1'b1;
        cfg_lanes_d     = lanes_q;
        state_d         = S_TPS;
      end
      S_TPS: begin
        cfg_tps_vld_d = 1'b1;
        cfg_tps_d     = tps_field_c;
        att_d         = att_q + 5'd1;
        try_d         = (att_q >= 5'd15) ? 4'd15 : 4'(att_q + 5'd1);
        settle_d      = '0;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 8'(P_SETTLE - 1)) begin
          meas_d  = '0;
          state_d = S_MEAS;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      S_MEAS: begin
        if (STA_CYCLE_IN >= win_eff_c) begin
          state_d = S_EVAL;
        end else if (meas_q == 16'hFFFE) begin
          err_d   = 1'b1;
          pass_d  = '0;
          state_d = S_DONE;
        end else begin
          meas_d = meas_q + 16'd1;
        end
      end
      S_EVAL: begin
        pass_d = pass_c;
        if (pass_c == act_c)               state_d = S_DONE;
        else if (32'(att_q) <= P_RETRY)    state_d = S_TPS;
        else                               state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ABORT_IN && (state_q != S_IDLE)) begin
      state_d         = S_IDLE;
      cfg_lanes_d     = cfg_lanes_q;
      cfg_lanes_vld_d = 1'b0;
      cfg_tps_d       = cfg_tps_q;
      cfg_tps_vld_d   = 1'b0;
      done_d          = 1'b0;
      pass_d          = '0;
      err_d           = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, captured request and registered outputs
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q         <= S_IDLE;
      lanes_q         <= '0;
      tps_q           <= '0;
      win_q           <= '0;
      thr_q           <= '0;
      settle_q        <= '0;
      meas_q          <= '0;
      att_q           <= '0;
      cfg_lanes_q     <= '0;
      cfg_lanes_vld_q <= 1'b0;
      cfg_tps_q       <= '0;
      cfg_tps_vld_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= '0;
      err_q           <= 1'b0;
      try_q           <= '0;
    end else begin
      state_q         <= state_d;
      lanes_q         <= lanes_d;
      tps_q           <= tps_d;
      win_q           <= win_d;
      thr_q           <= thr_d;
      settle_q        <= settle_d;
      meas_q          <= meas_d;
      att_q           <= att_d;
      cfg_lanes_q     <= cfg_lanes_d;
      cfg_lanes_vld_q <= cfg_lanes_vld_d;
      cfg_tps_q       <= cfg_tps_d;
      cfg_tps_vld_q   <= cfg_tps_vld_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_q           <= err_d;
      try_q           <= try_d;
    end
  end

  assign CFG_LANES_OUT     = cfg_lanes_q;
  assign CFG_LANES_VLD_OUT = cfg_lanes_vld_q;
  assign CFG_TPS_OUT       = cfg_tps_q;
  assign CFG_TPS_VLD_OUT   = cfg_tps_vld_q;
  assign BUSY_OUT          = busy_q;
  assign DONE_OUT          = done_q;
  assign PASS_OUT          = pass_q;
  assign ERR_OUT           = err_q;
  assign TRY_OUT           = try_q;

endmodule

// File: tb/tb_prt_dprx_trn_seq.sv
// Bench for prt_dprx_trn_seq: models the training block's counters, runs
// directed and randomized training checks against a per-attempt reference.
module tb_prt_dprx_trn_seq;

  localparam int unsigned LANES  = 2;
  localparam int unsigned RETRY  = 3;
  localparam int unsigned SETTLE = 8;

  logic        RST_IN = 1'b1;
  logic        CLK_IN = 1'b0;
  logic        START_IN = 1'b0;
  logic        ABORT_IN = 1'b0;
  logic [2:0]  ACT_LANES_IN = '0;
  logic [2:0]  TPS_IN = '0;
  logic [15:0] WIN_IN = '0;
  logic [15:0] THR_IN = '0;
  logic [2:0]  CFG_LANES_OUT;
  logic        CFG_LANES_VLD_OUT;
  logic [15:0] CFG_TPS_OUT;
  logic        CFG_TPS_VLD_OUT;
  logic [15:0] STA_CYCLE_IN = '0;
  logic [31:0] STA_MATCH_IN = '0;
  logic        BUSY_OUT;
  logic        DONE_OUT;
  logic [3:0]  PASS_OUT;
  logic        ERR_OUT;
  logic [3:0]  TRY_OUT;

  prt_dprx_trn_seq #(.P_LANES(LANES), .P_RETRY(RETRY), .P_SETTLE(SETTLE)) dut (
    .RST_IN(RST_IN), .CLK_IN(CLK_IN), .START_IN(START_IN), .ABORT_IN(ABORT_IN),
    .ACT_LANES_IN(ACT_LANES_IN), .TPS_IN(TPS_IN), .WIN_IN(WIN_IN), .THR_IN(THR_IN),
    .CFG_LANES_OUT(CFG_LANES_OUT), .CFG_LANES_VLD_OUT(CFG_LANES_VLD_OUT),
    .CFG_TPS_OUT(CFG_TPS_OUT), .CFG_TPS_VLD_OUT(CFG_TPS_VLD_OUT),
    .STA_CYCLE_IN(STA_CYCLE_IN), .STA_MATCH_IN(STA_MATCH_IN),
    .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT), .PASS_OUT(PASS_OUT),
    .ERR_OUT(ERR_OUT), .TRY_OUT(TRY_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_lanes = 0, n_tps = 0, n_done = 0, overlap = 0;
  int          last_tps_cyc = 0, done_cyc = 0;
  logic [2:0]  last_lanes = '0;
  logic [15:0] last_tps = '0;
  logic [15:0] sta_cyc = '0;
  bit          hold_zero = 0;
  logic [15:0] mt [0:16][0:1];

  always @(posedge CLK_IN) cyc <= cyc + 1;

  // Training-block model: counters restart on every TPS write
  always @(negedge CLK_IN) begin
    int idx;
    if (CFG_LANES_VLD_OUT) begin n_lanes++; last_lanes = CFG_LANES_OUT; end
    if (CFG_LANES_VLD_OUT && CFG_TPS_VLD_OUT) overlap++;
    if (DONE_OUT) n_done++;
    if (CFG_TPS_VLD_OUT) begin
      n_tps++;
      last_tps = CFG_TPS_OUT;
      last_tps_cyc = cyc;
      sta_cyc = '0;
      idx = (n_tps > 16) ? 16 : n_tps;
      STA_MATCH_IN = {mt[idx][1], mt[idx][0]};
    end else if (sta_cyc != 16'hFFFF) begin
      sta_cyc = sta_cyc + 16'd1;
    end
    STA_CYCLE_IN = hold_zero ? 16'd0 : sta_cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mt(input logic [15:0] m0, input logic [15:0] m1);
    for (int a = 0; a <= 16; a++) begin mt[a][0] = m0; mt[a][1] = m1; end
  endtask

  task automatic launch(input logic [2:0] l, input logic [2:0] t,
                        input logic [15:0] w, input logic [15:0] th);
    n_lanes = 0; n_tps = 0; n_done = 0; overlap = 0;
    ACT_LANES_IN = l; TPS_IN = t; WIN_IN = w; THR_IN = th;
    START_IN = 1'b1;
    @(negedge CLK_IN);
    START_IN = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (DONE_OUT === 1'b1) begin seen = 1; done_cyc = cyc; break; end
      @(negedge CLK_IN);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK_IN);
  endtask

  // Reference: grade attempt by attempt until all active lanes pass or retries run out
  task automatic ref_model(input int lanes, input logic [15:0] thr,
                           output int etry, output logic [3:0] epass);
    logic [3:0] mask;
    etry = 0; epass = '0;
    for (int a = 1; a <= int'(RETRY) + 1; a++) begin
      mask = '0;
      for (int l = 0; l < lanes; l++) if (mt[a][l] >= thr) mask[l] = 1'b1;
      etry = a; epass = mask;
      if (mask == 4'((1 << lanes) - 1)) break;
    end
  endtask

  function automatic logic [15:0] tps_word(input int lanes, input logic [2:0] t);
    logic [15:0] w;
    w = '0;
    for (int l = 0; l < lanes; l++) w = w | (16'(t) << (4 * l));
    return w;
  endfunction

  initial begin
    bit          seen;
    int          lanes, etry, thr_i;
    logic [2:0]  tps;
    logic [15:0] win, thr;
    logic [3:0]  epass;

    // Reset values
    #3;
    chk("rst_cfg_lanes", 32'(CFG_LANES_OUT), 0);
    chk("rst_cfg_tps", 32'(CFG_TPS_OUT), 0);
    chk("rst_strobes", 32'({CFG_LANES_VLD_OUT, CFG_TPS_VLD_OUT}), 0);
    chk("rst_busy_done", 32'({BUSY_OUT, DONE_OUT}), 0);
    chk("rst_pass_err_try", 32'({PASS_OUT, ERR_OUT, TRY_OUT}), 0);
    @(negedge CLK_IN); RST_IN = 1'b0;
    steps(2);

    // Both lanes pass on first attempt
    set_mt(16'd100, 16'd95);
    launch(3'd2, 3'd1, 16'd100, 16'd90);
    chk("busy_after_start", 32'(BUSY_OUT), 1);
    wait_done(2000, seen);
    chk("basic_done_seen", 32'(seen), 1);
    chk("basic_pass", 32'(PASS_OUT), 32'h3);
    chk("basic_try", 32'(TRY_OUT), 1);
    chk("basic_err", 32'(ERR_OUT), 0);
    chk("basic_latency", 32'(done_cyc - last_tps_cyc), 103);
    steps(2);
    chk("basic_lanes_cnt", 32'(n_lanes), 1);
    chk("basic_lanes_val", 32'(last_lanes), 2);
    chk("basic_tps_cnt", 32'(n_tps), 1);
    chk("basic_tps_val", 32'(last_tps), 32'h0011);
    chk("basic_done_cnt", 32'(n_done), 1);
    chk("basic_busy_low", 32'(BUSY_OUT), 0);

    // Lane 1 never passes: retries exhausted
    set_mt(16'd100, 16'd50);
    launch(3'd2, 3'd1, 16'd20, 16'd90);
    wait_done(2000, seen);
    chk("retry_done_seen", 32'(seen), 1);
    chk("retry_pass", 32'(PASS_OUT), 32'h1);
    chk("retry_try", 32'(TRY_OUT), 4);
    chk("retry_err", 32'(ERR_OUT), 0);
    steps(2);
    chk("retry_tps_cnt", 32'(n_tps), 4);

    // Threshold boundary: equal passes, one below fails
    set_mt(16'd500, 16'd499);
    launch(3'd2, 3'd5, 16'd0, 16'd500);
    wait_done(2000, seen);
    chk("thr_edge_pass", 32'(PASS_OUT), 32'h1);
    chk("thr_edge_try", 32'(TRY_OUT), 4);
    steps(2);

    // Invalid lane counts
    for (int k = 0; k < 3; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'd4 : (k == 1) ? 3'd3 : 3'd0;
      launch(bad, 3'd2, 16'd10, 16'd1);
      chk("inv_done_early", 32'(DONE_OUT), 0);
      @(negedge CLK_IN);
      chk("inv_done_t2", 32'(DONE_OUT), 1);
      chk("inv_err", 32'(ERR_OUT), 1);
      chk("inv_pass_try", 32'({PASS_OUT, TRY_OUT}), 0);
      steps(3);
      chk("inv_no_strobes", 32'(n_lanes + n_tps), 0);
    end

    // Abort during measurement, with a stray START while busy
    set_mt(16'd100, 16'd100);
    launch(3'd2, 3'd3, 16'd300, 16'd10);
    steps(1);
    START_IN = 1'b1; @(negedge CLK_IN); START_IN = 1'b0;
    for (int i = 0; i < 50 && n_tps == 0; i++) @(negedge CLK_IN);
    steps(SETTLE + 4);
    ABORT_IN = 1'b1; @(negedge CLK_IN); ABORT_IN = 1'b0;
    chk("abort_busy", 32'(BUSY_OUT), 0);
    chk("abort_err", 32'(ERR_OUT), 1);
    chk("abort_pass", 32'(PASS_OUT), 0);
    steps(400);
    chk("abort_no_done", 32'(n_done), 0);
    chk("abort_strobes", 32'({n_lanes[7:0], n_tps[7:0]}), 32'h0101);

    // Abort together with START in IDLE
    n_lanes = 0; n_tps = 0;
    ACT_LANES_IN = 3'd1; START_IN = 1'b1; ABORT_IN = 1'b1;
    @(negedge CLK_IN); START_IN = 1'b0; ABORT_IN = 1'b0;
    chk("abort_start_busy", 32'(BUSY_OUT), 0);
    steps(4);
    chk("abort_start_strobes", 32'(n_lanes + n_tps), 0);

    // Randomized sequences against the reference
    for (int n = 0; n < 12; n++) begin
      lanes = ($urandom_range(0, 1) == 0) ? 1 : 2;
      tps   = 3'($urandom_range(0, 7));
      win   = 16'($urandom_range(0, 30));
      thr_i = int'($urandom_range(1, 60000));
      thr   = 16'(thr_i);
      for (int a = 0; a <= 16; a++)
        for (int l = 0; l < 2; l++)
          mt[a][l] = ($urandom_range(0, 3) != 0) ? 16'(thr_i + int'($urandom_range(0, 2)))
                                                 : 16'(thr_i - 1 - int'($urandom_range(0, thr_i - 1)));
      ref_model(lanes, thr, etry, epass);
      launch(3'(lanes), tps, win, thr);
      wait_done(2000, seen);
      chk("rnd_done_seen", 32'(seen), 1);
      chk("rnd_pass", 32'(PASS_OUT), 32'(epass));
      chk("rnd_try", 32'(TRY_OUT), 32'(etry));
      chk("rnd_err", 32'(ERR_OUT), 0);
      steps(2);
      chk("rnd_tps_cnt", 32'(n_tps), 32'(etry));
      chk("rnd_tps_val", 32'(last_tps), 32'(tps_word(lanes, tps)));
      chk("rnd_lanes_val", 32'(last_lanes), 32'(lanes));
    end

    // Reset during settle, then a clean run
    set_mt(16'd100, 16'd100);
    launch(3'd2, 3'd6, 16'd20, 16'd10);
    for (int i = 0; i < 50 && n_tps == 0; i++) @(negedge CLK_IN);
    steps(2);
    RST_IN = 1'b1;
    #1;
    chk("mrst_cfg", 32'({CFG_LANES_OUT, CFG_TPS_OUT}), 0);
    chk("mrst_busy_done", 32'({BUSY_OUT, DONE_OUT, CFG_LANES_VLD_OUT, CFG_TPS_VLD_OUT}), 0);
    chk("mrst_pass_err_try", 32'({PASS_OUT, ERR_OUT, TRY_OUT}), 0);
    @(negedge CLK_IN); RST_IN = 1'b0;
    steps(60);
    chk("mrst_no_done", 32'(n_done), 0);
    launch(3'd2, 3'd6, 16'd20, 16'd10);
    wait_done(2000, seen);
    chk("mrst_rerun_pass", 32'({PASS_OUT, ERR_OUT, TRY_OUT}), 32'({4'h3, 1'b0, 4'd1}));
    steps(2);
    chk("mrst_rerun_tps", 32'(last_tps), 32'h0066);

    // Window never completes: measurement timeout
    hold_zero = 1;
    set_mt(16'd100, 16'd100);
    launch(3'd1, 3'd2, 16'd5, 16'd10);
    wait_done(70000, seen);
    chk("tmo_done_seen", 32'(seen), 1);
    chk("tmo_err", 32'(ERR_OUT), 1);
    chk("tmo_pass", 32'(PASS_OUT), 0);
    chk("tmo_latency", 32'(done_cyc - last_tps_cyc), 32'(SETTLE + 65536));
    hold_zero = 0;
    steps(2);
    chk("never_overlap", 32'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
